output_channel_scheduler: RTL and testbench
===========================================

// Module: output_channel_scheduler
// PURPOSE
// Sequences the output multiplexer's channel-select input and captures the selected wavelet word.
// Supports manual, continuous round-robin scan and single-sweep modes.
// Each captured word leaves on a valid/ready stream tagged with its channel number.
// Sits between the config registers and the output pads, wrapped around output_multiplexer.
// PARAMETERS
// NUM_FILTERS     8  number of wavelet channels (scan range 0..NUM_FILTERS-1)
// SUM_TRUNCATION  8  width of each truncated wavelet word
// DWELL_WIDTH     8  width of dwell counter / i_dwell
// PORTS
// clk                      in   1               system clock
// rst_n                    in   1               asynchronous, active-low reset
// i_mode                   in   2               0 OFF, 1 MANUAL, 2 SCAN, 3 SINGLE
// i_manual_channel         in   8               channel used in MANUAL
// i_channel_enable         in   NUM_FILTERS     per-channel enable mask for SCAN/SINGLE
// i_dwell                  in   DWELL_WIDTH     extra wait cycles before capture
// i_start                  in   1               1-cycle pulse, starts a SINGLE sweep
// i_mux_data               in   SUM_TRUNCATION  registered word from output multiplexer
// o_select_output_channel  out  8               drives multiplexer select (registered)
// o_sample                 out  SUM_TRUNCATION  captured word
// o_sample_channel         out  8               channel tag of o_sample
// o_valid                  out  1               o_sample/o_sample_channel valid
// i_ready                  in   1               downstream accepts when o_valid & i_ready
// o_busy                   out  1               high in any state except IDLE
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE; all outputs 0; scan pointer 0; dwell counter 0.
// - FSM: IDLE -> SELECT -> SETTLE -> DWELL -> OUTPUT -> (SELECT | IDLE).
// - IDLE: MANUAL, or SCAN with a nonzero mask -> SELECT. SINGLE with i_start=1 and a nonzero mask -> SELECT, pointer reset to 0.
// - SELECT (1 cycle):
//   - register the channel into o_select_output_channel; latch i_dwell into the counter.
//   - MANUAL channel >= NUM_FILTERS: select 0 and tag 0, matching the mux default.
//   - SCAN/SINGLE channel: lowest enabled index >= pointer; SCAN wraps past NUM_FILTERS-1 to 0.
// - SETTLE (1 cycle): covers the mux register stage.
//   - Select registered at edge E -> word captured no earlier than edge E+2.
// - DWELL: decrement until 0, then go to OUTPUT. Dwell 0 goes straight through (zero cycles).
// - OUTPUT:
//   - load o_sample=i_mux_data and o_sample_channel at entry; assert o_valid.
//   - o_sample, o_sample_channel and o_valid hold stable until i_ready.
//   - o_valid drops in the cycle after the handshake unless the next word is immediately valid; it never toggles while stalled.
// - After the handshake:
//   - pointer = served channel + 1.
//   - SINGLE: last enabled channel served -> IDLE (exactly one word per enabled channel).
//   - otherwise: mode OFF -> IDLE; else -> SELECT.
// - Mode, mask and manual-channel changes are sampled only in IDLE and SELECT; a word in flight always completes.
// - Mask becomes 0 mid-scan: finish the current word, then IDLE.
// - i_start outside IDLE, or outside SINGLE mode, is ignored.
// - Full-rate path (dwell 0, i_ready held 1): one word per 4 cycles (SELECT, SETTLE, OUTPUT, handshake).
// - Reset mid-operation: immediate return to IDLE; any pending word is discarded with no handshake.
// STRUCTURE
// - Shared package wavelet_pkg: mode encodings (MODE_OFF/MANUAL/SCAN/SINGLE), FSM state enum, CHANNEL_SEL_WIDTH=8.
// - Sub-module next_enabled_channel (combinational): mask + pointer + wrap flag -> index, found flag.
// - Multiplexer instantiated at top level, not inside this block.
// TESTING
// - MANUAL ch 3, dwell 0, ready=1 -> select=3 and a word with tag 3 every 4 cycles; o_sample equals the mux word for ch 3.
// - SCAN mask 8'b1010_0101, dwell 2, ready=1 -> tags 0,2,5,7,0,... in order; 6 cycles per word.
// - SINGLE mask 8'h81, start pulse -> exactly two words (tags 0, 7), then o_busy=0; a second start repeats the sweep.
// - SCAN with ready=0 for 10 cycles -> o_valid stays 1 and sample/tag stable; select unchanged until ready.
// - MANUAL ch 12 -> select 0, tag 0; mode->OFF mid-dwell -> current word delivered, then IDLE.
// - rst_n low during OUTPUT -> all outputs 0 asynchronously; after release with mode SCAN, restarts at lowest enabled channel.

Source files
------------

// File: rtl/output_channel_scheduler_pkg.sv
// Shared definitions for the wavelet output path: mode encodings, scheduler
// FSM states and the multiplexer channel-select width.
package wavelet_pkg;

  localparam int CHANNEL_SEL_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_SINGLE = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DWELL  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

endpackage

// File: rtl/output_channel_scheduler_if.sv
// Valid/ready stream carrying a captured wavelet word and its channel tag.
interface output_channel_scheduler_if
  import wavelet_pkg::*;
#(
  parameter int SUM_TRUNCATION = 8
) ();

  logic [SUM_TRUNCATION-1:0]    o_sample;
  logic [CHANNEL_SEL_WIDTH-1:0] o_sample_channel;
  logic                         o_valid;
  logic                         i_ready;

  modport master (
    output o_sample,
    output o_sample_channel,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_sample,
    input  o_sample_channel,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/output_channel_scheduler_next.sv
// Finds the lowest enabled channel at or above a pointer, optionally wrapping
// back to the lowest enabled channel overall.
module next_enabled_channel
  import wavelet_pkg::*;
#(
  parameter int NUM_FILTERS = 8
) (
  input  logic [NUM_FILTERS-1:0]       mask,
  input  logic [CHANNEL_SEL_WIDTH-1:0] pointer,
  input  logic                         wrap,
  output logic [CHANNEL_SEL_WIDTH-1:0] index,
  output logic                         found
);

  always_comb begin
    index = '0;
    found = 1'b0;
    // Descending walk: the last hit is the lowest qualifying index.
    for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
      if (mask[NUM_FILTERS-1-i] &&
          CHANNEL_SEL_WIDTH'(NUM_FILTERS-1-i) >= pointer) begin
        index = CHANNEL_SEL_WIDTH'(NUM_FILTERS-1-i);
        found = 1'b1;
      end
    end
    if (!found && wrap) begin
      for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
        if (mask[NUM_FILTERS-1-i]) begin
          index = CHANNEL_SEL_WIDTH'(NUM_FILTERS-1-i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/output_channel_scheduler.sv
// Drives the output multiplexer channel select and captures the selected word
// onto a tagged valid/ready stream (manual, round-robin scan, single sweep).
module output_channel_scheduler
  import wavelet_pkg::*;
#(
  parameter int NUM_FILTERS    = 8,
  parameter int SUM_TRUNCATION = 8,
  parameter int DWELL_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   i_mode,
  input  logic [CHANNEL_SEL_WIDTH-1:0] i_manual_channel,
  input  logic [NUM_FILTERS-1:0]       i_channel_enable,
  input  logic [DWELL_WIDTH-1:0]       i_dwell,
  input  logic                         i_start,
  input  logic [SUM_TRUNCATION-1:0]    i_mux_data,
  output logic [CHANNEL_SEL_WIDTH-1:0] o_select_output_channel,
  output logic                         o_busy,
  output_channel_scheduler_if.master   stream
);

  state_t                       state_q;
  mode_t                        mode_q;
  mode_t                        mode_in;
  logic [NUM_FILTERS-1:0]       mask_q;
  logic [CHANNEL_SEL_WIDTH-1:0] ptr_q;
  logic [CHANNEL_SEL_WIDTH-1:0] cur_ch_q;
  logic [DWELL_WIDTH-1:0]       dwell_q;
  logic [CHANNEL_SEL_WIDTH-1:0] nxt_idx;
  logic                         nxt_found;
  logic                         mask_nz;
  logic                         more_above;

  assign mode_in = mode_t'(i_mode);
  assign mask_nz = |i_channel_enable;
  assign o_busy  = (state_q != ST_IDLE);

  next_enabled_channel #(
    .NUM_FILTERS(NUM_FILTERS)
  ) u_next (
    .mask    (i_channel_enable),
    .pointer (ptr_q),
    .wrap    (mode_in == MODE_SCAN),
    .index   (nxt_idx),
    .found   (nxt_found)
  );

  // A single sweep ends once no channel above the served one is enabled.
  always_comb begin
    more_above = 1'b0;
    for (int unsigned j = 0; j < NUM_FILTERS; j++) begin
      if (mask_q[j] && CHANNEL_SEL_WIDTH'(j) > cur_ch_q) more_above = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                 <= ST_IDLE;
      mode_q                  <= MODE_OFF;
      mask_q                  <= '0;
      ptr_q                   <= '0;
      cur_ch_q                <= '0;
      dwell_q                 <= '0;
      o_select_output_channel <= '0;
      stream.o_sample         <= '0;
      stream.o_sample_channel <= '0;
      stream.o_valid          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mode_in == MODE_MANUAL ||
              (mode_in == MODE_SCAN && mask_nz) ||
              (mode_in == MODE_SINGLE && i_start && mask_nz)) begin
            state_q <= ST_SELECT;
            ptr_q   <= '0;
          end
        end
        ST_SELECT: begin
          mode_q  <= mode_in;
          mask_q  <= i_channel_enable;
          dwell_q <= i_dwell;
          case (mode_in)
            MODE_MANUAL: begin
              if (i_manual_channel < CHANNEL_SEL_WIDTH'(NUM_FILTERS)) begin
                o_select_output_channel <= i_manual_channel;
                cur_ch_q                <= i_manual_channel;
              end else begin
                o_select_output_channel <= '0;
                cur_ch_q                <= '0;
              end
              state_q <= ST_SETTLE;
            end
            MODE_SCAN, MODE_SINGLE: begin
              if (nxt_found) begin
                o_select_output_channel <= nxt_idx;
                cur_ch_q                <= nxt_idx;
                state_q                 <= ST_SETTLE;
              end else begin
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_SETTLE: begin
          state_q <= (dwell_q == '0) ? ST_OUTPUT : ST_DWELL;
        end
        ST_DWELL: begin
          dwell_q <= dwell_q - DWELL_WIDTH'(1);
          if (dwell_q == DWELL_WIDTH'(1)) state_q <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          // First OUTPUT cycle captures (two edges after select); then hold for ready.
          if (!stream.o_valid) begin
            stream.o_sample         <= i_mux_data;
            stream.o_sample_channel <= cur_ch_q;
            stream.o_valid          <= 1'b1;
          end else if (stream.i_ready) begin
            stream.o_valid <= 1'b0;
            ptr_q          <= cur_ch_q + CHANNEL_SEL_WIDTH'(1);
            if ((mode_q == MODE_SINGLE && !more_above) || mode_in == MODE_OFF)
              state_q <= ST_IDLE;
            else
              state_q <= ST_SELECT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_channel_scheduler.sv
// Directed bench for output_channel_scheduler with a registered multiplexer model.
module tb_output_channel_scheduler;
  import wavelet_pkg::*;

  localparam int NF = 8;
  localparam int ST = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic [7:0]    i_manual_channel = '0;
  logic [NF-1:0] i_channel_enable = '0;
  logic [DW-1:0] i_dwell = '0;
  logic          i_start = 1'b0;
  logic [ST-1:0] mux_data;
  logic [7:0]    sel;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int q_tag[$];
  int q_smp[$];
  int q_cyc[$];

  output_channel_scheduler_if #(.SUM_TRUNCATION(ST)) stream ();

  output_channel_scheduler #(
    .NUM_FILTERS(NF),
    .SUM_TRUNCATION(ST),
    .DWELL_WIDTH(DW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .i_mode                  (i_mode),
    .i_manual_channel        (i_manual_channel),
    .i_channel_enable        (i_channel_enable),
    .i_dwell                 (i_dwell),
    .i_start                 (i_start),
    .i_mux_data              (mux_data),
    .o_select_output_channel (sel),
    .o_busy                  (busy),
    .stream                  (stream)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] word_of(input logic [7:0] ch);
    return 8'h30 + ch * 8'h11;
  endfunction

  // Registered output multiplexer model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mux_data <= '0;
    else        mux_data <= word_of(sel);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && stream.o_valid && stream.i_ready) begin
      q_tag.push_back(int'(stream.o_sample_channel));
      q_smp.push_back(int'(stream.o_sample));
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_tag.delete();
    q_smp.delete();
    q_cyc.delete();
  endtask

  task automatic wait_words(input int n, input int bound);
    for (int i = 0; i < bound && q_tag.size() < n; i++) tick();
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stream.i_ready = 1'b0;
    tick();
    tick();
    total++; if (sel !== 8'd0) begin bad++; $display("FAIL reset_select got=%0d exp=0", sel); end
    total++; if (stream.o_sample !== 8'd0) begin bad++; $display("FAIL reset_sample got=%0h exp=0", stream.o_sample); end
    total++; if (stream.o_sample_channel !== 8'd0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", stream.o_sample_channel); end
    total++; if (stream.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", stream.o_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_off_busy got=%b exp=0", busy); end
  endtask

  task automatic test_manual();
    clear_q();
    i_manual_channel = 8'd3;
    i_dwell = '0;
    stream.i_ready = 1'b1;
    i_mode = 2'(MODE_MANUAL);
    wait_words(4, 40);
    total++; if (q_tag.size() < 4) begin bad++; $display("FAIL manual_words got=%0d exp=4", q_tag.size()); end
    total++; if (sel !== 8'd3) begin bad++; $display("FAIL manual_select got=%0d exp=3", sel); end
    for (int k = 0; k < q_tag.size() && k < 4; k++) begin
      total++; if (q_tag[k] !== 3) begin bad++; $display("FAIL manual_tag[%0d] got=%0d exp=3", k, q_tag[k]); end
      total++; if (q_smp[k] !== int'(word_of(8'd3))) begin bad++; $display("FAIL manual_sample[%0d] got=%0h exp=%0h", k, q_smp[k], word_of(8'd3)); end
      if (k > 0) begin
        total++; if (q_cyc[k] - q_cyc[k-1] !== 4) begin bad++; $display("FAIL manual_period[%0d] got=%0d exp=4", k, q_cyc[k] - q_cyc[k-1]); end
      end
    end
    i_mode = 2'(MODE_OFF);
    wait_idle(20);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL manual_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_scan();
    int exp_tags[5] = '{0, 2, 5, 7, 0};
    clear_q();
    i_channel_enable = 8'b1010_0101;
    i_dwell = 8'd2;
    stream.i_ready = 1'b1;
    i_mode = 2'(MODE_SCAN);
    wait_words(5, 60);
    total++; if (q_tag.size() < 5) begin bad++; $display("FAIL scan_words got=%0d exp=5", q_tag.size()); end
    for (int k = 0; k < q_tag.size() && k < 5; k++) begin
      total++; if (q_tag[k] !== exp_tags[k]) begin bad++; $display("FAIL scan_tag[%0d] got=%0d exp=%0d", k, q_tag[k], exp_tags[k]); end
      total++; if (q_smp[k] !== int'(word_of(8'(exp_tags[k])))) begin bad++; $display("FAIL scan_sample[%0d] got=%0h exp=%0h", k, q_smp[k], word_of(8'(exp_tags[k]))); end
      if (k > 0) begin
        total++; if (q_cyc[k] - q_cyc[k-1] !== 6) begin bad++; $display("FAIL scan_period[%0d] got=%0d exp=6", k, q_cyc[k] - q_cyc[k-1]); end
      end
    end
    i_mode = 2'(MODE_OFF);
    wait_idle(20);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    i_channel_enable = 8'h81;
    i_dwell = '0;
    stream.i_ready = 1'b1;
    i_mode = 2'(MODE_SINGLE);
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_wait_start got=%b exp=0", busy); end
    for (int run = 0; run < 2; run++) begin
      clear_q();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      if (run == 1) begin
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
      end
      wait_idle(40);
      for (int i = 0; i < 6; i++) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single%0d_busy got=%b exp=0", run, busy); end
      total++; if (q_tag.size() !== 2) begin bad++; $display("FAIL single%0d_count got=%0d exp=2", run, q_tag.size()); end
      if (q_tag.size() >= 2) begin
        total++; if (q_tag[0] !== 0) begin bad++; $display("FAIL single%0d_tag0 got=%0d exp=0", run, q_tag[0]); end
        total++; if (q_tag[1] !== 7) begin bad++; $display("FAIL single%0d_tag1 got=%0d exp=7", run, q_tag[1]); end
        total++; if (q_smp[1] !== int'(word_of(8'd7))) begin bad++; $display("FAIL single%0d_sample1 got=%0h exp=%0h", run, q_smp[1], word_of(8'd7)); end
      end
    end
    i_mode = 2'(MODE_OFF);
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] smp0, tag0, sel0;
    int n;
    clear_q();
    i_channel_enable = 8'b1010_0101;
    i_dwell = '0;
    stream.i_ready = 1'b0;
    i_mode = 2'(MODE_SCAN);
    n = 0;
    while (!stream.o_valid && n < 20) begin tick(); n++; end
    total++; if (stream.o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_rise got=%b exp=1", stream.o_valid); end
    smp0 = stream.o_sample;
    tag0 = stream.o_sample_channel;
    sel0 = sel;
    total++; if (tag0 !== 8'd0) begin bad++; $display("FAIL stall_tag got=%0d exp=0", tag0); end
    total++; if (smp0 !== word_of(8'd0)) begin bad++; $display("FAIL stall_sample got=%0h exp=%0h", smp0, word_of(8'd0)); end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (stream.o_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid[%0d] got=%b exp=1", i, stream.o_valid); end
      total++; if (stream.o_sample !== word_of(8'd0) || stream.o_sample_channel !== 8'd0) begin bad++; $display("FAIL stall_hold_word[%0d] got=%0h/%0d exp=%0h/0", i, stream.o_sample, stream.o_sample_channel, word_of(8'd0)); end
      total++; if (sel !== 8'd0) begin bad++; $display("FAIL stall_hold_select[%0d] got=%0d exp=0", i, sel); end
    end
    stream.i_ready = 1'b1;
    tick();
    total++; if (stream.o_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop got=%b exp=0", stream.o_valid); end
    total++; if (q_tag.size() !== 1) begin bad++; $display("FAIL stall_one_handshake got=%0d exp=1", q_tag.size()); end
    wait_words(2, 20);
    total++; if (q_tag.size() < 2 || q_tag[1] !== 2) begin bad++; $display("FAIL stall_next_tag got=%0d exp=2", (q_tag.size() < 2) ? -1 : q_tag[1]); end
    i_mode = 2'(MODE_OFF);
    wait_idle(20);
  endtask

  task automatic test_manual_oob_off();
    clear_q();
    i_manual_channel = 8'd12;
    i_dwell = 8'd20;
    stream.i_ready = 1'b1;
    i_mode = 2'(MODE_MANUAL);
    tick();
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL oob_busy got=%b exp=1", busy); end
    total++; if (sel !== 8'd0) begin bad++; $display("FAIL oob_select got=%0d exp=0", sel); end
    i_mode = 2'(MODE_OFF);
    wait_words(1, 40);
    total++; if (q_tag.size() < 1 || q_tag[0] !== 0) begin bad++; $display("FAIL oob_tag got=%0d exp=0", (q_tag.size() < 1) ? -1 : q_tag[0]); end
    total++; if (q_smp.size() < 1 || q_smp[0] !== int'(word_of(8'd0))) begin bad++; $display("FAIL oob_sample got=%0h exp=%0h", (q_smp.size() < 1) ? -1 : q_smp[0], word_of(8'd0)); end
    wait_idle(10);
    for (int i = 0; i < 8; i++) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL off_idle_busy got=%b exp=0", busy); end
    total++; if (q_tag.size() !== 1) begin bad++; $display("FAIL off_word_count got=%0d exp=1", q_tag.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_q();
    i_channel_enable = 8'h24;
    i_dwell = '0;
    stream.i_ready = 1'b0;
    i_mode = 2'(MODE_SCAN);
    n = 0;
    while (!stream.o_valid && n < 20) begin tick(); n++; end
    total++; if (stream.o_valid !== 1'b1) begin bad++; $display("FAIL rmid_valid got=%b exp=1", stream.o_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (stream.o_valid !== 1'b0) begin bad++; $display("FAIL rmid_async_valid got=%b exp=0", stream.o_valid); end
    total++; if (stream.o_sample !== 8'd0 || stream.o_sample_channel !== 8'd0) begin bad++; $display("FAIL rmid_async_word got=%0h/%0d exp=0/0", stream.o_sample, stream.o_sample_channel); end
    total++; if (sel !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async_sel_busy got=%0d/%b exp=0/0", sel, busy); end
    tick();
    tick();
    rst_n = 1'b1;
    stream.i_ready = 1'b1;
    wait_words(1, 20);
    total++; if (q_tag.size() < 1 || q_tag[0] !== 2) begin bad++; $display("FAIL rmid_restart_tag got=%0d exp=2", (q_tag.size() < 1) ? -1 : q_tag[0]); end
    total++; if (q_smp.size() < 1 || q_smp[0] !== int'(word_of(8'd2))) begin bad++; $display("FAIL rmid_restart_sample got=%0h exp=%0h", (q_smp.size() < 1) ? -1 : q_smp[0], word_of(8'd2)); end
    i_mode = 2'(MODE_OFF);
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_single();
    test_stall();
    test_manual_oob_off();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
